// File: rtl/pc_redirect_if.sv
// Front-end redirect bundle between the fetch-PC owner and its surroundings:
// stall/handshake from fetch, branch/exception resolution from EX, flush controls to IF/ID.
interface pc_redirect_if;
  logic        stall;
  logic        fetch_ready;
  logic        br_valid;
  logic        br_taken;
  logic [31:0] br_pc;
  logic [31:0] br_target;
  logic        exc_valid;
  logic [31:0] exc_target;
  logic [31:0] fetch_pc;
  logic        fetch_req;
  logic        flush_req;
  logic [31:0] flush_keep_pc;
  logic        flush_all;
  logic        redirect_busy;

  modport master (
    output stall, fetch_ready, br_valid, br_taken, br_pc, br_target, exc_valid, exc_target,
    input  fetch_pc, fetch_req, flush_req, flush_keep_pc, flush_all, redirect_busy
  );

  modport slave (
    input  stall, fetch_ready, br_valid, br_taken, br_pc, br_target, exc_valid, exc_target,
    output fetch_pc, fetch_req, flush_req, flush_keep_pc, flush_all, redirect_busy
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC owner for the MIPS front end: sequential fetch, branch redirects with
// delay-slot handling, and exception redirects that override everything else.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input logic         clk,
  input logic         rst,
  pc_redirect_if.slave bus
);

  typedef enum logic {SEQ, WAIT_DS} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] keep_q, keep_d;
  logic        flush_req_q, flush_req_d;
  logic        flush_all_q, flush_all_d;
  logic        rst_d;

  logic        acc;
  logic        br_redirect;
  logic [31:0] ds_pc;
  logic        ds_fetched;

  assign acc         = bus.fetch_req & bus.fetch_ready;
  assign br_redirect = bus.br_valid & bus.br_taken & (state_q == SEQ);
  assign ds_pc       = bus.br_pc + 32'd4;
  // The delay slot counts as fetched once fetch_pc has already moved past it.
  assign ds_fetched  = (pc_q != ds_pc);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) state_q <= SEQ;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.exc_valid) begin
      state_d = SEQ;
    end else begin
      case (state_q)
        SEQ:     if (br_redirect && !ds_fetched && !acc) state_d = WAIT_DS;
        WAIT_DS: if (acc) state_d = SEQ;
        default: state_d = SEQ;
      endcase
    end
  end

  always_comb begin
    bus.redirect_busy = (state_q == WAIT_DS);
    // Request is also masked in the reset cycle itself, before rst_d is known.
    bus.fetch_req     = ~rst & ~rst_d & ~bus.stall;
  end

  // NOTE: every comb output takes a default first so no path can infer a latch.
  always_comb begin
    pc_d        = pc_q;
    pend_d      = pend_q;
    keep_d      = keep_q;
    flush_req_d = 1'b0;
    flush_all_d = 1'b0;
    if (bus.exc_valid) begin
      pc_d        = bus.exc_target;
      pend_d      = '0;
      flush_all_d = 1'b1;
    end else if (br_redirect) begin
      if (ds_fetched) begin
        pc_d        = bus.br_target;
        flush_req_d = 1'b1;
        keep_d      = ds_pc;
      end else if (acc) begin
        pc_d = bus.br_target;
      end else begin
        pend_d = bus.br_target;
      end
    end else if (state_q == WAIT_DS) begin
      if (acc) pc_d = pend_q;
    end else if (acc) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // NOTE: reset is synchronous and covers every register here, including the
  // pending target, so a reset during WAIT_DS leaves nothing stale behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      pend_q      <= '0;
      keep_q      <= '0;
      flush_req_q <= 1'b0;
      flush_all_q <= 1'b0;
      rst_d       <= 1'b1;
    end else begin
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      keep_q      <= keep_d;
      flush_req_q <= flush_req_d;
      flush_all_q <= flush_all_d;
      rst_d       <= 1'b0;
    end
  end

  assign bus.fetch_pc      = pc_q;
  assign bus.flush_req     = flush_req_q;
  assign bus.flush_keep_pc = keep_q;
  assign bus.flush_all     = flush_all_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: sequential fetch, delay-slot cases,
// exception priority, wraparound and reset during a pending redirect.
module tb_pc_redirect_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  pc_redirect_if bus ();

  pc_redirect_ctrl #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input logic taken, input logic [31:0] pc, input logic [31:0] tgt);
    bus.br_valid  = 1'b1;
    bus.br_taken  = taken;
    bus.br_pc     = pc;
    bus.br_target = tgt;
  endtask

  task automatic no_branch();
    bus.br_valid  = 1'b0;
    bus.br_taken  = 1'b0;
    bus.br_pc     = '0;
    bus.br_target = '0;
  endtask

  initial begin
    rst             = 1'b1;
    bus.stall       = 1'b0;
    bus.fetch_ready = 1'b0;
    bus.exc_valid   = 1'b0;
    bus.exc_target  = '0;
    no_branch();

    // Reset cycle
    tick();
    check("rst_pc",        bus.fetch_pc,      32'hBFC0_0000);
    check("rst_req",       32'(bus.fetch_req), 0);
    check("rst_flush_req", 32'(bus.flush_req), 0);
    check("rst_flush_all", 32'(bus.flush_all), 0);
    check("rst_busy",      32'(bus.redirect_busy), 0);
    check("rst_keep",      bus.flush_keep_pc, 32'h0);

    rst = 1'b0;
    bus.fetch_ready = 1'b1;
    #1;
    check("deassert_req", 32'(bus.fetch_req), 0);

    tick();
    check("seq0_pc",  bus.fetch_pc, 32'hBFC0_0000);
    check("seq0_req", 32'(bus.fetch_req), 1);
    tick(); check("seq1_pc", bus.fetch_pc, 32'hBFC0_0004);
    tick(); check("seq2_pc", bus.fetch_pc, 32'hBFC0_0008);
    tick(); check("seq3_pc", bus.fetch_pc, 32'hBFC0_000C);
    tick(); tick(); tick();
    check("seq6_pc", bus.fetch_pc, 32'hBFC0_0018);

    // Delay slot already fetched
    branch(1'b1, 32'hBFC0_0010, 32'hBFC0_0100);
    tick();
    check("dsf_pc",    bus.fetch_pc,       32'hBFC0_0100);
    check("dsf_flush", 32'(bus.flush_req), 1);
    check("dsf_keep",  bus.flush_keep_pc,  32'hBFC0_0014);
    no_branch();
    tick();
    check("dsf_flush_clr", 32'(bus.flush_req), 0);
    check("dsf_next_pc",   bus.fetch_pc,       32'hBFC0_0104);

    // Steer to BFC00014, then delay slot not fetched with imem not ready
    branch(1'b1, 32'h0000_0000, 32'hBFC0_0014);
    tick();
    check("steer1_pc", bus.fetch_pc, 32'hBFC0_0014);
    bus.fetch_ready = 1'b0;
    branch(1'b1, 32'hBFC0_0010, 32'hBFC0_0100);
    tick();
    check("wait1_pc",    bus.fetch_pc,           32'hBFC0_0014);
    check("wait1_busy",  32'(bus.redirect_busy), 1);
    check("wait1_flush", 32'(bus.flush_req),     0);
    no_branch();
    tick();
    check("wait2_pc",   bus.fetch_pc,           32'hBFC0_0014);
    check("wait2_busy", 32'(bus.redirect_busy), 1);
    bus.fetch_ready = 1'b1;
    tick();
    check("wait_acc_pc",    bus.fetch_pc,           32'hBFC0_0100);
    check("wait_acc_busy",  32'(bus.redirect_busy), 0);
    check("wait_acc_flush", 32'(bus.flush_req),     0);

    // Same-cycle delay-slot accept
    branch(1'b1, 32'h0000_0000, 32'hBFC0_0014);
    tick();
    check("steer2_pc", bus.fetch_pc, 32'hBFC0_0014);
    branch(1'b1, 32'hBFC0_0010, 32'hBFC0_0100);
    tick();
    check("same_pc",    bus.fetch_pc,           32'hBFC0_0100);
    check("same_busy",  32'(bus.redirect_busy), 0);
    check("same_flush", 32'(bus.flush_req),     0);

    // Exception while in WAIT_DS, with an ignored same-cycle branch
    branch(1'b1, 32'h0000_0000, 32'hBFC0_0014);
    tick();
    bus.fetch_ready = 1'b0;
    branch(1'b1, 32'hBFC0_0010, 32'hBFC0_0100);
    tick();
    check("exc_pre_busy", 32'(bus.redirect_busy), 1);
    bus.exc_valid  = 1'b1;
    bus.exc_target = 32'hBFC0_0380;
    branch(1'b1, 32'hBFC0_0010, 32'hBFC0_0700);
    tick();
    check("exc_pc",        bus.fetch_pc,           32'hBFC0_0380);
    check("exc_flush_all", 32'(bus.flush_all),     1);
    check("exc_busy",      32'(bus.redirect_busy), 0);
    check("exc_flush_req", 32'(bus.flush_req),     0);
    bus.exc_valid   = 1'b0;
    bus.fetch_ready = 1'b1;
    no_branch();
    tick();
    check("exc_next_pc",   bus.fetch_pc,       32'hBFC0_0384);
    check("exc_all_clr",   32'(bus.flush_all), 0);

    // Exception beats a same-cycle taken branch in SEQ; flush_all wins
    bus.exc_valid  = 1'b1;
    bus.exc_target = 32'hFFFF_FFF8;
    branch(1'b1, 32'h0000_0000, 32'h0000_0500);
    tick();
    check("excb_pc",        bus.fetch_pc,       32'hFFFF_FFF8);
    check("excb_flush_all", 32'(bus.flush_all), 1);
    check("excb_flush_req", 32'(bus.flush_req), 0);
    bus.exc_valid = 1'b0;

    // Not-taken branch: sequential, no flush
    branch(1'b0, 32'hFFFF_FFF4, 32'h0000_0500);
    tick();
    check("nt_pc",    bus.fetch_pc,           32'hFFFF_FFFC);
    check("nt_flush", 32'(bus.flush_req),     0);
    check("nt_busy",  32'(bus.redirect_busy), 0);
    no_branch();
    tick();
    check("wrap_pc", bus.fetch_pc, 32'h0000_0000);

    // br_pc+4 wraps to match fetch_pc 0; then reset in WAIT_DS
    bus.fetch_ready = 1'b0;
    branch(1'b1, 32'hFFFF_FFFC, 32'h0000_0600);
    tick();
    check("wrapds_pc",   bus.fetch_pc,           32'h0000_0000);
    check("wrapds_busy", 32'(bus.redirect_busy), 1);
    no_branch();
    rst = 1'b1;
    tick();
    check("rstw_pc",   bus.fetch_pc,           32'hBFC0_0000);
    check("rstw_busy", 32'(bus.redirect_busy), 0);
    check("rstw_req",  32'(bus.fetch_req),     0);
    rst = 1'b0;
    bus.fetch_ready = 1'b1;
    tick();
    check("rstw_hold_pc", bus.fetch_pc, 32'hBFC0_0000);
    tick();
    check("rstw_seq_pc",  bus.fetch_pc, 32'hBFC0_0004);

    // Stall blocks fetch but not redirect capture
    bus.stall = 1'b1;
    #1;
    check("stall_req", 32'(bus.fetch_req), 0);
    branch(1'b1, 32'hBFC0_0100, 32'hBFC0_0200);
    tick();
    check("stall_br_pc",    bus.fetch_pc,       32'hBFC0_0200);
    check("stall_br_flush", 32'(bus.flush_req), 1);
    check("stall_br_keep",  bus.flush_keep_pc,  32'hBFC0_0104);
    no_branch();
    tick();
    check("stall_hold_pc", bus.fetch_pc, 32'hBFC0_0200);
    bus.stall = 1'b0;
    tick();
    check("unstall_pc", bus.fetch_pc, 32'hBFC0_0204);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
